// File: rtl/aes_mix_columns_seq.sv
// aes_mix_columns_seq: multi-cycle AES (Inv)MixColumns engine with valid/ready handshakes
module aes_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  localparam int NSTEP = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  logic [1:0]   state, cnt;
  logic         mode_r, last;
  logic [127:0] work, next_work;
  logic [6:0]   lsb     [COLS_PER_CYCLE];
  logic [31:0]  col_in  [COLS_PER_CYCLE];
  logic [31:0]  col_out [COLS_PER_CYCLE];
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  // Each output byte is a rotating sum of four coefficient products; the
  // inverse coefficients 0e/0b/0d/09 are assembled from x2, x4 and x8.
  function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] p0 [4];
    logic [7:0] p1 [4];
    logic [7:0] p2 [4];
    logic [7:0] p3 [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a  = c[31-8*r -: 8];
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      p0[r] = inv ? x8 ^ x4 ^ x2 : x2;
      p1[r] = inv ? x8 ^ x2 ^ a  : x2 ^ a;
      p2[r] = inv ? x8 ^ x4 ^ a  : a;
      p3[r] = inv ? x8 ^ a       : a;
    end
    for (int r = 0; r < 4; r++)
      res[31-8*r -: 8] = p0[r] ^ p1[(r+1)%4] ^ p2[(r+2)%4] ^ p3[(r+3)%4];
    return res;
  endfunction
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign lsb[k]     = 7'(96 - 32 * (int'(cnt) * COLS_PER_CYCLE + k));
    assign col_in[k]  = work[lsb[k] +: 32];
    assign col_out[k] = mix(col_in[k], (INV_EN != 0) && mode_r);
  end
  assign last      = cnt == 2'(NSTEP - 1);
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = state == DONE;
  assign busy      = (state == BUSY) | (state == DONE);
  // Write the freshly mixed column group back into the working state
  always_comb begin
    next_work = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) next_work[lsb[k] +: 32] = col_out[k];
  end
  // Handshake FSM; state_out only changes when a complete result lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      mode_r    <= 1'b0;
      work      <= '0;
      state_out <= '0;
    end else if (in_valid && in_ready) begin
      state  <= BUSY;
      cnt    <= 2'd0;
      mode_r <= (INV_EN != 0) && mode;
      work   <= state_in;
    end else if (state == BUSY) begin
      work <= next_work;
      cnt  <= cnt + 2'd1;
      if (last) begin
        state     <= DONE;
        state_out <= next_work;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// tb_aes_mix_columns_seq: directed checks of the sequential MixColumns engine in four configurations
module tb_aes_mix_columns_seq;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready, mode;
  logic [127:0] state_in;
  logic         in_ready  [4];
  logic         out_valid [4];
  logic         busy      [4];
  logic [127:0] state_out [4];
  int lat [4];
  int nstep [4] = '{4, 2, 1, 4};
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] KC_IN    = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] KC_OUT   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  always #5 clk = ~clk;

  aes_mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1)) dut0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .state_in(state_in), .mode(mode), .out_valid(out_valid[0]), .out_ready(out_ready), .state_out(state_out[0]), .busy(busy[0]));
  aes_mix_columns_seq #(.COLS_PER_CYCLE(2), .INV_EN(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .state_in(state_in), .mode(mode), .out_valid(out_valid[1]), .out_ready(out_ready), .state_out(state_out[1]), .busy(busy[1]));
  aes_mix_columns_seq #(.COLS_PER_CYCLE(4), .INV_EN(1)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .state_in(state_in), .mode(mode), .out_valid(out_valid[2]), .out_ready(out_ready), .state_out(state_out[2]), .busy(busy[2]));
  aes_mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(0)) dut3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]), .state_in(state_in), .mode(mode), .out_valid(out_valid[3]), .out_ready(out_ready), .state_out(state_out[3]), .busy(busy[3]));

  task automatic start(input logic [127:0] s, input logic m);
    @(negedge clk);
    state_in = s;
    mode = m;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (out_valid[i] && lat[i] == 0) lat[i] = e;
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 1'b0;
    state_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d got rdy=%b vld=%b busy=%b want 1 0 0", i, in_ready[i], out_valid[i], busy[i]);
      end
      checks++;
      if (state_out[i] !== '0) begin
        errors++;
        $display("FAIL reset_out dut%0d got %h want 0", i, state_out[i]);
      end
    end
  endtask

  task automatic test_forward;
    logic [127:0] vin  [3] = '{FIPS_IN, KC_IN, 128'h0};
    logic [127:0] vexp [3] = '{FIPS_OUT, KC_OUT, 128'h0};
    for (int v = 0; v < 3; v++) begin
      start(vin[v], 1'b0);
      wait_done;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lat[i] !== nstep[i]) begin
          errors++;
          $display("FAIL fwd_latency v%0d dut%0d got %0d want %0d", v, i, lat[i], nstep[i]);
        end
        checks++;
        if (state_out[i] !== vexp[v]) begin
          errors++;
          $display("FAIL fwd_result v%0d dut%0d got %h want %h", v, i, state_out[i], vexp[v]);
        end
      end
      release_out;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
          errors++;
          $display("FAIL fwd_release v%0d dut%0d got vld=%b rdy=%b want 0 1", v, i, out_valid[i], in_ready[i]);
        end
      end
    end
  endtask

  task automatic test_inverse;
    logic [127:0] r, f;
    start(KC_OUT, 1'b1);
    wait_done;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state_out[i] !== KC_IN) begin
        errors++;
        $display("FAIL inv_result dut%0d got %h want %h", i, state_out[i], KC_IN);
      end
    end
    release_out;
    r = {$urandom, $urandom, $urandom, $urandom};
    start(r, 1'b0);
    wait_done;
    f = state_out[0];
    release_out;
    start(f, 1'b1);
    wait_done;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state_out[i] !== r) begin
        errors++;
        $display("FAIL round_trip dut%0d got %h want %h", i, state_out[i], r);
      end
    end
    release_out;
  endtask

  task automatic test_back_to_back;
    start(FIPS_IN, 1'b0);
    wait_done;
    @(negedge clk);
    state_in = 128'h0123456789abcdef0011223344556677;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (state_out[i] !== FIPS_OUT || out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0) begin
          errors++;
          $display("FAIL hold dut%0d got %h vld=%b rdy=%b want %h 1 0", i, state_out[i], out_valid[i], in_ready[i], FIPS_OUT);
        end
      end
    end
    @(negedge clk);
    state_in = KC_IN;
    mode = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready dut%0d got %b want 1", i, in_ready[i]);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept dut0 got busy=%b vld=%b want 1 0", busy[0], out_valid[0]);
    end
    wait_done;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lat[i] !== nstep[i] || state_out[i] !== KC_OUT) begin
        errors++;
        $display("FAIL b2b_result dut%0d got lat=%0d %h want lat=%0d %h", i, lat[i], state_out[i], nstep[i], KC_OUT);
      end
    end
    release_out;
  endtask

  task automatic test_reset_mid;
    start(KC_IN, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b1 || out_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got busy0=%b vld2=%b want 1 1", busy[0], out_valid[2]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset dut%0d got vld=%b rdy=%b want 0 1", i, out_valid[i], in_ready[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    start(FIPS_IN, 1'b0);
    wait_done;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lat[i] !== nstep[i] || state_out[i] !== FIPS_OUT) begin
        errors++;
        $display("FAIL mid_after dut%0d got lat=%0d %h want lat=%0d %h", i, lat[i], state_out[i], nstep[i], FIPS_OUT);
      end
    end
    release_out;
  endtask

  task automatic test_inv_disabled;
    start(FIPS_IN, 1'b1);
    wait_done;
    checks++;
    if (lat[3] !== 4 || state_out[3] !== FIPS_OUT) begin
      errors++;
      $display("FAIL inv_disabled got lat=%0d %h want lat=4 %h", lat[3], state_out[3], FIPS_OUT);
    end
    release_out;
  endtask

  initial begin
    test_reset;
    test_forward;
    test_inverse;
    test_back_to_back;
    test_reset_mid;
    test_inv_disabled;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
